sha256_msg_sched: RTL and testbench

SHA-256 message schedule generator. Accepts one 512-bit padded message block and streams the 64 schedule words W0..W63, one word per handshake, to the compression round datapath. The round datapath sums each W_t with K_t and the working variables through the 32-bit adder blocks. This block owns block buffering, the 16-word sliding window and the sigma0/sigma1 expansion. The round datapath needs no knowledge of message layout.

---
 rtl/sha256_msg_sched.sv | 91 +++++++++
 tb/tb_sha256_msg_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit padded block and streams W0..W63
// from a 16-word sliding window, expanding new words with sigma0/sigma1.
module sha256_msg_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w_data,
   output logic [5:0]   w_idx,
   output logic         w_last
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [5:0]  t;
   logic [31:0] win [16];
   logic        load;
   logic        adv;
   logic [31:0] nxt;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Four-operand sum; the 32-bit result width discards carries out of bit 31.
   function automatic logic [31:0] add4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
      return a + b + c + d;
   endfunction

   assign nxt = add4(sigma1(win[14]), win[9], sigma0(win[1]), win[0]);

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      adv       = 1'b0;
      case (state)
         IDLE: begin
            if (blk_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_ready) begin
               adv = 1'b1;
               if (t == 6'd63) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Window and round counter; t wraps to 0 naturally after the W63 handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t <= 6'd0;
         for (int i = 0; i < 16; i++) win[i] <= 32'd0;
      end else if (load) begin
         t <= 6'd0;
         for (int i = 0; i < 16; i++) win[i] <= blk_data[32*(15-i) +: 32];
      end else if (adv) begin
         t <= t + 6'd1;
         for (int i = 0; i < 15; i++) win[i] <= win[i+1];
         win[15] <= nxt;
      end
   end

   assign blk_ready = (state == IDLE);
   assign w_valid   = (state == RUN);
   assign w_data    = win[0];
   assign w_idx     = t;
   assign w_last    = (state == RUN) && (t == 6'd63);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched against a plain-array SHA-256 schedule model.
module tb_sha256_msg_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_w   [64];
   logic [31:0] got_w   [64];
   logic [5:0]  got_idx [64];
   logic        got_last[64];
   int          hs_cnt;
   int          stall_viol;
   int          timeout;

   sha256_msg_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_idx     (w_idx),
      .w_last    (w_last)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Standard recurrence over the full W array.
   task automatic build_model(input logic [511:0] blk);
      for (int k = 0; k < 16; k++) exp_w[k] = blk[511 - 32*k -: 32];
      for (int k = 16; k < 64; k++)
         exp_w[k] = s1(exp_w[k-2]) + exp_w[k-7] + s0(exp_w[k-15]) + exp_w[k-16];
   endtask

   function automatic logic [511:0] rand_blk();
      logic [511:0] r;
      for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] abc_blk();
      logic [511:0] r;
      r = '0;
      r[511:480] = 32'h61626380;
      r[31:0]    = 32'h00000018;
      return r;
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after load.
   task automatic load_block(input logic [511:0] blk);
      blk_data  = blk;
      blk_valid = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
   endtask

   // Streams until 64 handshakes; returns at posedge+1 of the cycle after W63.
   task automatic collect(input int duty);
      logic [31:0] pd;
      logic [5:0]  pi;
      logic        stalled;
      stalled    = 1'b0;
      pd         = '0;
      pi         = '0;
      hs_cnt     = 0;
      stall_viol = 0;
      timeout    = 0;
      for (int c = 0; c < 2000 && hs_cnt < 64; c++) begin
         w_ready = ($urandom_range(99) < duty);
         if (stalled && (w_data !== pd || w_idx !== pi)) stall_viol++;
         if (w_valid && w_ready) begin
            got_w[hs_cnt]    = w_data;
            got_idx[hs_cnt]  = w_idx;
            got_last[hs_cnt] = w_last;
            hs_cnt++;
            stalled = 1'b0;
         end else begin
            stalled = w_valid;
            pd      = w_data;
            pi      = w_idx;
         end
         @(posedge clk); #1;
      end
      w_ready = 1'b0;
      if (hs_cnt < 64) timeout = 1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      blk_valid = 1'b0;
      w_ready   = 1'b0;
      blk_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (blk_ready !== 1'b1 || w_valid !== 1'b0 || w_idx !== 6'd0 || w_data !== 32'd0 || w_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got rdy=%b vld=%b idx=%0d data=%h last=%b expected 1 0 0 00000000 0",
                  blk_ready, w_valid, w_idx, w_data, w_last);
      end
      load_block(abc_blk());
      w_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (w_idx !== 6'd20) begin
         errors++;
         $display("FAIL midrun_idx: got %0d expected 20", w_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (blk_ready !== 1'b1 || w_valid !== 1'b0 || w_idx !== 6'd0 || w_data !== 32'd0 || w_last !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got rdy=%b vld=%b idx=%0d data=%h last=%b expected 1 0 0 00000000 0",
                  blk_ready, w_valid, w_idx, w_data, w_last);
      end
      w_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic check_stream(input string name);
      checks++;
      if (timeout != 0) begin
         errors++;
         $display("FAIL %s_timeout: got %0d handshakes expected 64", name, hs_cnt);
      end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got_w[k] !== exp_w[k] || got_idx[k] !== 6'(k) || got_last[k] !== (k == 63)) begin
            errors++;
            $display("FAIL %s_w%0d: got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                     name, k, got_w[k], got_idx[k], got_last[k], exp_w[k], k, (k == 63));
         end
      end
      checks++;
      if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_end_ready: got rdy=%b vld=%b expected 1 0", name, blk_ready, w_valid);
      end
   endtask

   task automatic test_abc();
      build_model(abc_blk());
      load_block(abc_blk());
      checks++;
      if (w_valid !== 1'b1 || w_data !== 32'h61626380 || w_idx !== 6'd0 || blk_ready !== 1'b0) begin
         errors++;
         $display("FAIL abc_w0_latency: got vld=%b data=%h idx=%0d rdy=%b expected 1 61626380 0 0",
                  w_valid, w_data, w_idx, blk_ready);
      end
      collect(100);
      checks++;
      if (got_w[15] !== 32'h00000018 || got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000) begin
         errors++;
         $display("FAIL abc_known: got W15=%h W16=%h W17=%h expected 00000018 61626380 000f0000",
                  got_w[15], got_w[16], got_w[17]);
      end
      check_stream("abc");
   endtask

   task automatic test_single_bit();
      logic [511:0] b;
      b = '0;
      b[511:480] = 32'h00000001;
      build_model(b);
      load_block(b);
      collect(100);
      checks++;
      if (got_w[16] !== 32'h00000001) begin
         errors++;
         $display("FAIL single_w16: got %h expected 00000001", got_w[16]);
      end
      check_stream("single");
   endtask

   task automatic test_all_ones();
      logic [511:0] b;
      b = '1;
      build_model(b);
      load_block(b);
      collect(100);
      check_stream("ones");
   endtask

   task automatic test_backpressure();
      build_model(abc_blk());
      load_block(abc_blk());
      collect(50);
      checks++;
      if (stall_viol != 0) begin
         errors++;
         $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_viol);
      end
      check_stream("bp");
   endtask

   task automatic test_random_blocks();
      logic [511:0] b;
      for (int n = 0; n < 3; n++) begin
         b = rand_blk();
         build_model(b);
         load_block(b);
         collect(70);
         checks++;
         if (stall_viol != 0) begin
            errors++;
            $display("FAIL rand_stable: got %0d unstable stall cycles expected 0", stall_viol);
         end
         check_stream("rand");
      end
   endtask

   task automatic test_back_to_back();
      logic [511:0] a, b;
      logic [31:0]  exp_a[64];
      int           hs, rdy_viol;
      a = rand_blk();
      b = rand_blk();
      build_model(a);
      for (int k = 0; k < 64; k++) exp_a[k] = exp_w[k];
      build_model(b);
      blk_data  = a;
      blk_valid = 1'b1;
      @(posedge clk); #1;
      hs       = 0;
      rdy_viol = 0;
      for (int c = 0; c < 500 && hs < 64; c++) begin
         blk_data = (hs < 40) ? rand_blk() : b;
         w_ready  = ($urandom_range(99) < 80);
         if (blk_ready !== 1'b0) rdy_viol++;
         if (w_valid && w_ready) begin
            got_w[hs]   = w_data;
            got_idx[hs] = w_idx;
            hs++;
         end
         @(posedge clk); #1;
      end
      w_ready = 1'b0;
      checks++;
      if (hs != 64 || rdy_viol != 0) begin
         errors++;
         $display("FAIL b2b_a_run: got hs=%0d ready_in_run=%0d expected 64 0", hs, rdy_viol);
      end
      for (int k = 0; k < 64; k++) begin
         checks++;
         if (got_w[k] !== exp_a[k] || got_idx[k] !== 6'(k)) begin
            errors++;
            $display("FAIL b2b_a_w%0d: got data=%h idx=%0d expected data=%h idx=%0d",
                     k, got_w[k], got_idx[k], exp_a[k], k);
         end
      end
      checks++;
      if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_gap: got rdy=%b vld=%b expected 1 0", blk_ready, w_valid);
      end
      @(posedge clk); #1;
      blk_valid = 1'b0;
      checks++;
      if (w_valid !== 1'b1 || w_idx !== 6'd0 || w_data !== exp_w[0]) begin
         errors++;
         $display("FAIL b2b_b_w0: got vld=%b idx=%0d data=%h expected 1 0 %h",
                  w_valid, w_idx, w_data, exp_w[0]);
      end
      collect(100);
      check_stream("b2b_b");
   endtask

   initial begin
      test_reset();
      test_abc();
      test_single_bit();
      test_all_ones();
      test_backpressure();
      test_random_blocks();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
